seq_bit_source: RTL and testbench

Upstream stage of the sequence detector. Captures a WIDTH-bit pattern from the board switches on a debounced button press. Serializes the pattern MSB-first onto the detector's X input, one bit per DIV clock cycles. Produces a one-cycle strobe per bit, which the detector stage uses as its advance enable.

---
 rtl/seq_bit_source_pkg.sv | 18 +
 rtl/seq_bit_source_btn_debounce.sv | 60 ++++++
 rtl/seq_bit_source.sv | 121 ++++++++++++
 tb/tb_seq_bit_source.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_bit_source_pkg.sv
// Shared definitions for the sequence-detector front end: FSM encoding and
// the common bit-rate / debounce defaults used by every stage.
package seq_bit_source_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_DIV    = 50_000_000;
    localparam int DEF_DB_CYC = 1_000_000;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_bit_source_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import seq_bit_source_pkg::*;
#(
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic LVL,
    output logic RISE
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic          r_lvl_d;
    logic          r_arm;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The synchronizer comes out of reset at the pressed level and rising
    // edges stay disarmed until a released level is seen, so a button held
    // through reset needs a release before it can load again.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_arm   <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= BTN_IN;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            r_rise  <= r_lvl & ~r_lvl_d & r_arm;
            if (!r_s2) begin
                r_arm <= 1'b1;
            end
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_lvl <= ~r_lvl;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign LVL  = r_lvl;
    assign RISE = r_rise;

endmodule

// File: rtl/seq_bit_source.sv
// Loads a switch pattern on a debounced button press and streams it MSB-first
// onto the detector's X input, one bit per DIV cycles with a per-bit strobe.
module seq_bit_source
    import seq_bit_source_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIV    = DEF_DIV,
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW,
    input  logic             LD_BTN,
    output logic             X,
    output logic             X_VLD,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(WIDTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);

    logic             w_ldp;
    logic             w_unused_lvl;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_sh, w_sh_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic [PW-1:0]    r_pre, w_pre_nx;
    logic             r_x, w_x_nx;
    logic             r_vld, w_vld_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;

    btn_debounce #(
        .DB_CYC (DB_CYC)
    ) u_ld_db (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_IN (LD_BTN),
        .LVL    (w_unused_lvl),
        .RISE   (w_ldp)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_idx   <= '0;
            r_pre   <= '0;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sh    <= w_sh_nx;
            r_idx   <= w_idx_nx;
            r_pre   <= w_pre_nx;
            r_x     <= w_x_nx;
            r_vld   <= w_vld_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Outputs are computed one cycle ahead so X/X_VLD/BUSY/DONE leave flops.
    always_comb begin
        w_state_nx = r_state;
        w_sh_nx    = r_sh;
        w_idx_nx   = r_idx;
        w_pre_nx   = r_pre;
        w_x_nx     = r_x;
        w_vld_nx   = 1'b0;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_ldp) begin
                    w_state_nx = S_SHIFT;
                    w_sh_nx    = SW;
                    w_idx_nx   = IDX_TOP;
                    w_pre_nx   = '0;
                    w_x_nx     = SW[WIDTH-1];
                    w_vld_nx   = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_done_nx  = 1'b0;
                end
            end
            S_SHIFT: begin
                if (r_pre == PRE_LAST) begin
                    w_pre_nx = '0;
                    if (r_idx == '0) begin
                        w_state_nx = S_DONE;
                        w_x_nx     = 1'b0;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_sh_nx  = r_sh << 1;
                        w_idx_nx = r_idx - 1'b1;
                        w_x_nx   = r_sh[WIDTH-2];
                        w_vld_nx = 1'b1;
                    end
                end else begin
                    w_pre_nx = r_pre + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign X     = r_x;
    assign X_VLD = r_vld;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_seq_bit_source.sv
// Bench for seq_bit_source: press/transfer scenarios against an event-level
// reference model, plus table-driven and hand-written corner cases.
module tb_seq_bit_source;

    localparam int WIDTH  = 6;
    localparam int DIV    = 4;
    localparam int DB_CYC = 3;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] SW;
    logic             LD_BTN;
    logic             X;
    logic             X_VLD;
    logic             BUSY;
    logic             DONE;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit             mq[$];
    bit             sq[$];
    int             m_e;
    bit             m_lvl;
    bit             m_armed;
    bit             m_active;
    int             m_S;
    int             m_start_at;
    logic [WIDTH-1:0] m_pat;
    logic           ex, ev, eb, ed;

    // per-run observations
    int             mon_k;
    int             mon_first;
    int             mon_pulses;
    logic [WIDTH-1:0] mon_bits;
    int             mon_done_k;
    logic           mon_done_prev;

    typedef struct {
        logic [WIDTH-1:0] sw;
        int               hold;
        int               first;
        int               pulses;
        logic [WIDTH-1:0] bits;
        int               done;
    } vec_t;

    vec_t vecs[5];
    int   bounce[8];

    seq_bit_source #(
        .WIDTH  (WIDTH),
        .DIV    (DIV),
        .DB_CYC (DB_CYC)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SW     (SW),
        .LD_BTN (LD_BTN),
        .X      (X),
        .X_VLD  (X_VLD),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq = {1'b1, 1'b1};
        sq.delete();
        m_e        = 0;
        m_lvl      = 1'b0;
        m_armed    = 1'b0;
        m_active   = 1'b0;
        m_S        = 0;
        m_start_at = -1;
        m_pat      = '0;
        {ex, ev, eb, ed} = 4'b0000;
    endtask

    // Transfer in progress: bit j/DIV of the captured pattern, strobe on the
    // first cycle of each bit; afterwards DONE until the next accepted load.
    task automatic model_outputs();
        int j;
        if (!m_active) begin
            {ex, ev, eb, ed} = 4'b0000;
        end else if (m_e - m_S < DIV * WIDTH) begin
            j  = m_e - m_S;
            ex = m_pat[WIDTH-1-j/DIV];
            ev = (j % DIV == 0);
            eb = 1'b1;
            ed = 1'b0;
        end else begin
            {ex, ev, eb, ed} = 4'b0001;
        end
    endtask

    // The button is seen two edges late; the level changes once DB_CYC
    // consecutive seen samples disagree with it; an accepted press starts
    // a transfer two edges after that unless one is still running.
    task automatic model_edge();
        bit syncv;
        bit all_diff;
        if (RST) begin
            model_reset();
            return;
        end
        m_e++;
        syncv = mq[mq.size()-2];
        mq.push_back(LD_BTN);
        sq.push_back(syncv);
        if (!syncv) m_armed = 1'b1;
        if (m_start_at == m_e && (!m_active || m_e >= m_S + DIV * WIDTH + 1)) begin
            m_active = 1'b1;
            m_S      = m_e;
            m_pat    = SW;
        end
        if (sq.size() >= DB_CYC) begin
            all_diff = 1'b1;
            for (int i = 1; i <= DB_CYC; i++) begin
                if (sq[sq.size()-i] == m_lvl) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_lvl = !m_lvl;
                if (m_lvl && m_armed) m_start_at = m_e + 2;
            end
        end
        model_outputs();
    endtask

    task automatic mon_clear();
        mon_k         = 0;
        mon_first     = -1;
        mon_pulses    = 0;
        mon_bits      = '0;
        mon_done_k    = -1;
        mon_done_prev = DONE;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        chk("outputs{X,X_VLD,BUSY,DONE}", {28'd0, X, X_VLD, BUSY, DONE}, {28'd0, ex, ev, eb, ed});
        if (X_VLD === 1'b1) begin
            if (mon_first < 0) mon_first = mon_k;
            mon_pulses++;
            mon_bits = {mon_bits[WIDTH-2:0], X};
        end
        if (DONE === 1'b1 && mon_done_prev !== 1'b1 && mon_done_k < 0) mon_done_k = mon_k;
        mon_done_prev = DONE;
        mon_k++;
    endtask

    task automatic check_run(input string name, input int first, input int pulses,
                             input logic [WIDTH-1:0] bits, input int done_k);
        chk({name, "_first_vld"}, mon_first, first);
        chk({name, "_pulses"}, mon_pulses, pulses);
        chk({name, "_bits"}, {26'd0, mon_bits}, {26'd0, bits});
        chk({name, "_done_edge"}, mon_done_k, done_k);
    endtask

    initial begin
        vecs[0] = '{sw: 6'b011101, hold: 10,  first: 6,  pulses: 6, bits: 6'b011101, done: 30};
        vecs[1] = '{sw: 6'b011001, hold: 10,  first: 6,  pulses: 6, bits: 6'b011001, done: 30};
        vecs[2] = '{sw: 6'b101010, hold: 2,   first: -1, pulses: 0, bits: 6'b000000, done: -1};
        vecs[3] = '{sw: 6'b110011, hold: 3,   first: 6,  pulses: 6, bits: 6'b110011, done: 30};
        vecs[4] = '{sw: 6'b100001, hold: 100, first: 6,  pulses: 6, bits: 6'b100001, done: 30};
        bounce  = '{1, 0, 1, 1, 0, 0, 1, 0};

        RST    = 1'b1;
        LD_BTN = 1'b0;
        SW     = '0;
        model_reset();
        #1;
        chk("reset_outputs", {28'd0, X, X_VLD, BUSY, DONE}, 0);
        repeat (3) cycle();
        RST = 1'b0;
        repeat (5) cycle();

        // table: clean presses, short press, DB_CYC boundary, long hold
        for (int v = 0; v < 5; v++) begin
            SW = vecs[v].sw;
            mon_clear();
            LD_BTN = 1'b1;
            for (int c = 0; c < vecs[v].hold; c++) cycle();
            LD_BTN = 1'b0;
            for (int c = 0; c < 40; c++) cycle();
            check_run($sformatf("vec%0d", v), vecs[v].first, vecs[v].pulses,
                      vecs[v].bits, vecs[v].done);
        end

        // second press and SW change during SHIFT are ignored
        SW = 6'b011101;
        mon_clear();
        LD_BTN = 1'b1;
        repeat (8) cycle();
        LD_BTN = 1'b0;
        SW = 6'b011001;
        repeat (6) cycle();
        LD_BTN = 1'b1;
        repeat (7) cycle();
        LD_BTN = 1'b0;
        repeat (40) cycle();
        check_run("press_in_shift", 6, 6, 6'b011101, 30);

        // bouncy press: high runs shorter than DB_CYC, then a stable hold
        SW = 6'b110100;
        mon_clear();
        for (int c = 0; c < 8; c++) begin
            LD_BTN = bounce[c][0];
            cycle();
        end
        LD_BTN = 1'b1;
        repeat (10) cycle();
        LD_BTN = 1'b0;
        repeat (40) cycle();
        check_run("bouncy", 14, 6, 6'b110100, 38);

        // asynchronous reset in the middle of bit 3 with the button held
        SW = 6'b011101;
        mon_clear();
        LD_BTN = 1'b1;
        repeat (20) cycle();
        chk("busy_before_rst", {31'd0, BUSY}, 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_outputs", {28'd0, X, X_VLD, BUSY, DONE}, 0);
        model_reset();
        repeat (2) cycle();
        RST = 1'b0;
        mon_clear();
        repeat (30) cycle();
        chk("held_after_rst_pulses", mon_pulses, 0);
        LD_BTN = 1'b0;
        repeat (10) cycle();
        mon_clear();
        LD_BTN = 1'b1;
        repeat (10) cycle();
        LD_BTN = 1'b0;
        repeat (30) cycle();
        check_run("repress_after_rst", 6, 6, 6'b011101, 30);

        // randomized presses and switch activity against the model
        for (int it = 0; it < 8; it++) begin
            int h;
            SW = 6'($urandom);
            for (int c = 0; c < 8; c++) begin
                LD_BTN = 1'($urandom);
                cycle();
            end
            h = $urandom_range(1, 12);
            LD_BTN = 1'b1;
            for (int c = 0; c < h; c++) cycle();
            LD_BTN = 1'b0;
            for (int c = 0; c < 40; c++) begin
                SW = 6'($urandom);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
